// File: rtl/plot_port_arbiter.sv
// rtl/plot_port_arbiter.sv - two-requester VGA pixel-port arbiter with clip and clear sweep
// Optional macro PLOT_ARB_RR_EN: round-robin arbitration instead of fixed priority 0 > 1.
module plot_port_arbiter #(
   parameter int         H_RES     = 320,
   parameter int         V_RES     = 240,
   parameter int         X_ORIGIN  = 160,
   parameter int         Y_ORIGIN  = 120,
   parameter logic [2:0] BG_COLOUR = 3'b000
) (
   input  logic        CLOCK_50,
   input  logic        resetn,
   input  logic        clear_req,
   output logic        clear_busy,
   output logic        clear_done,
   input  logic        req_valid0,
   input  logic [11:0] req_x0,
   input  logic [11:0] req_y0,
   input  logic [2:0]  req_col0,
   output logic        req_ready0,
   input  logic        req_valid1,
   input  logic [11:0] req_x1,
   input  logic [11:0] req_y1,
   input  logic [2:0]  req_col1,
   output logic        req_ready1,
   output logic [8:0]  vga_x,
   output logic [7:0]  vga_y,
   output logic [2:0]  vga_colour,
   output logic        vga_plot,
   output logic        clipped
);

   typedef enum logic {S_SERVE, S_CLEAR} state_t;

   state_t      state_q, state_d;
   logic [8:0]  cx_q, cx_d;
   logic [7:0]  cy_q, cy_d;
   logic [8:0]  vga_x_q, vga_x_d;
   logic [7:0]  vga_y_q, vga_y_d;
   logic [2:0]  vga_colour_q, vga_colour_d;
   logic        vga_plot_q, vga_plot_d;
   logic        clipped_q, clipped_d;
   logic        clear_done_q, clear_done_d;
   logic        grant0, grant1, serve;
   logic [11:0] sel_x, sel_y;
   logic [2:0]  sel_col;
   logic [12:0] sx, sy;
   logic        in_range;
`ifdef PLOT_ARB_RR_EN
   logic        ptr_q, ptr_d;
`endif

   always_comb begin
      serve = (state_q == S_SERVE);
`ifdef PLOT_ARB_RR_EN
      // On a tie the requester not named by the pointer wins.
      grant0 = req_valid0 & (~req_valid1 | ptr_q);
      grant1 = req_valid1 & (~req_valid0 | ~ptr_q);
`else
      grant0 = req_valid0;
      grant1 = req_valid1 & ~req_valid0;
`endif
      req_ready0 = serve & ~clear_req & grant0;
      req_ready1 = serve & ~clear_req & grant1;
`ifdef PLOT_ARB_RR_EN
      ptr_d = req_ready1 ? 1'b1 : (req_ready0 ? 1'b0 : ptr_q);
`endif

      sel_x   = req_ready1 ? req_x1   : req_x0;
      sel_y   = req_ready1 ? req_y1   : req_y0;
      sel_col = req_ready1 ? req_col1 : req_col0;
      // Math space has +y up and origin at centre; sign-extend to 13 bits first.
      sx = {sel_x[11], sel_x} + 13'(X_ORIGIN);
      sy = 13'(Y_ORIGIN) - {sel_y[11], sel_y};
      in_range = ~sx[12] && (sx < 13'(H_RES)) && ~sy[12] && (sy < 13'(V_RES));

      state_d      = state_q;
      cx_d         = cx_q;
      cy_d         = cy_q;
      vga_x_d      = vga_x_q;
      vga_y_d      = vga_y_q;
      vga_colour_d = vga_colour_q;
      vga_plot_d   = 1'b0;
      clipped_d    = 1'b0;
      clear_done_d = 1'b0;

      case (state_q)
         S_SERVE: begin
            if (clear_req) begin
               state_d = S_CLEAR;
               cx_d    = 9'd0;
               cy_d    = 8'd0;
            end else if (req_ready0 | req_ready1) begin
               if (in_range) begin
                  vga_plot_d   = 1'b1;
                  vga_x_d      = sx[8:0];
                  vga_y_d      = sy[7:0];
                  vga_colour_d = sel_col;
               end else begin
                  clipped_d = 1'b1;
               end
            end
         end
         S_CLEAR: begin
            vga_plot_d   = 1'b1;
            vga_x_d      = cx_q;
            vga_y_d      = cy_q;
            vga_colour_d = BG_COLOUR;
            if (cx_q == 9'(H_RES - 1)) begin
               cx_d = 9'd0;
               if (cy_q == 8'(V_RES - 1)) begin
                  cy_d         = 8'd0;
                  state_d      = S_SERVE;
                  clear_done_d = 1'b1;
               end else begin
                  cy_d = cy_q + 8'd1;
               end
            end else begin
               cx_d = cx_q + 9'd1;
            end
         end
         default: state_d = S_SERVE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q      <= S_SERVE;
         cx_q         <= 9'd0;
         cy_q         <= 8'd0;
         vga_x_q      <= 9'd0;
         vga_y_q      <= 8'd0;
         vga_colour_q <= 3'd0;
         vga_plot_q   <= 1'b0;
         clipped_q    <= 1'b0;
         clear_done_q <= 1'b0;
`ifdef PLOT_ARB_RR_EN
         ptr_q        <= 1'b1;
`endif
      end else begin
         state_q      <= state_d;
         cx_q         <= cx_d;
         cy_q         <= cy_d;
         vga_x_q      <= vga_x_d;
         vga_y_q      <= vga_y_d;
         vga_colour_q <= vga_colour_d;
         vga_plot_q   <= vga_plot_d;
         clipped_q    <= clipped_d;
         clear_done_q <= clear_done_d;
`ifdef PLOT_ARB_RR_EN
         ptr_q        <= ptr_d;
`endif
      end
   end

   assign clear_busy = (state_q == S_CLEAR);
   assign clear_done = clear_done_q;
   assign vga_x      = vga_x_q;
   assign vga_y      = vga_y_q;
   assign vga_colour = vga_colour_q;
   assign vga_plot   = vga_plot_q;
   assign clipped    = clipped_q;

endmodule

// File: tb/tb_plot_port_arbiter.sv
// tb/tb_plot_port_arbiter.sv - self-checking bench for plot_port_arbiter
// Honours PLOT_ARB_RR_EN for the tie-break expectations.
module tb_plot_port_arbiter;

   logic        clk = 1'b0;
   logic        resetn, clear_req, clear_busy, clear_done;
   logic        req_valid0, req_ready0, req_valid1, req_ready1;
   logic [11:0] req_x0, req_y0, req_x1, req_y1;
   logic [2:0]  req_col0, req_col1, vga_colour;
   logic [8:0]  vga_x;
   logic [7:0]  vga_y;
   logic        vga_plot, clipped;

   typedef struct {
      bit         clip;
      logic [8:0] x;
      logic [7:0] y;
      logic [2:0] col;
   } exp_t;

   exp_t q[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   plot_port_arbiter dut (
      .CLOCK_50(clk), .resetn(resetn), .clear_req(clear_req),
      .clear_busy(clear_busy), .clear_done(clear_done),
      .req_valid0(req_valid0), .req_x0(req_x0), .req_y0(req_y0),
      .req_col0(req_col0), .req_ready0(req_ready0),
      .req_valid1(req_valid1), .req_x1(req_x1), .req_y1(req_y1),
      .req_col1(req_col1), .req_ready1(req_ready1),
      .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
      .vga_plot(vga_plot), .clipped(clipped)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_model(input int x, input int y, input logic [2:0] col);
      exp_t e;
      int   sx, sy;
      sx = x + 160;
      sy = 120 - y;
      e.clip = !(sx >= 0 && sx < 320 && sy >= 0 && sy < 240);
      e.x    = 9'(sx);
      e.y    = 8'(sy);
      e.col  = col;
      q.push_back(e);
   endtask

   task automatic expect_out(input string tag);
      exp_t e;
      if (q.size() == 0) begin
         chk({tag, "_scoreboard_empty"}, 1, 0);
      end else begin
         e = q.pop_front();
         chk({tag, "_plot"}, vga_plot, !e.clip);
         chk({tag, "_clipped"}, clipped, e.clip);
         if (!e.clip) begin
            chk({tag, "_x"}, vga_x, e.x);
            chk({tag, "_y"}, vga_y, e.y);
            chk({tag, "_col"}, vga_colour, e.col);
         end
      end
   endtask

   task automatic send(input string tag, input int r, input int x, input int y, input logic [2:0] col);
      logic rdy;
      @(posedge clk); #1;
      if (r == 0) begin
         req_valid0 = 1'b1; req_x0 = 12'(x); req_y0 = 12'(y); req_col0 = col;
      end else begin
         req_valid1 = 1'b1; req_x1 = 12'(x); req_y1 = 12'(y); req_col1 = col;
      end
      @(negedge clk);
      rdy = (r == 0) ? req_ready0 : req_ready1;
      chk({tag, "_ready"}, rdy, 1);
      if (rdy) push_model(x, y, col);
      @(posedge clk); #1;
      req_valid0 = 1'b0;
      req_valid1 = 1'b0;
      @(negedge clk);
      if (rdy) expect_out(tag);
   endtask

   initial begin
      int   plots, dones, bad_col, bad_rdy, bad_idle, cyc;
      int   first_x, first_y, last_x, last_y;
      logic exp_g1 [4];
`ifdef PLOT_ARB_RR_EN
      exp_g1 = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
      exp_g1 = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
      resetn = 1'b0; clear_req = 1'b0;
      req_valid0 = 1'b0; req_x0 = '0; req_y0 = '0; req_col0 = '0;
      req_valid1 = 1'b0; req_x1 = '0; req_y1 = '0; req_col1 = '0;
      repeat (3) @(negedge clk);
      chk("rst_plot", vga_plot, 0);
      chk("rst_xy", {vga_x, vga_y, vga_colour}, 0);
      chk("rst_flags", {clipped, clear_busy, clear_done, req_ready0, req_ready1}, 0);
      @(posedge clk); #1 resetn = 1'b1;

      send("centre", 0, 0, 0, 3'b101);
      send("corner_tl", 1, -160, 120, 3'b010);
      send("corner_br", 1, 159, -119, 3'b111);

      // Tie between both requesters for four cycles.
      @(posedge clk); #1;
      req_valid0 = 1'b1; req_x0 = 12'd1; req_y0 = 12'd0; req_col0 = 3'b001;
      req_valid1 = 1'b1; req_x1 = 12'd2; req_y1 = 12'd0; req_col1 = 3'b100;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i > 0) expect_out("tie_out");
         chk("tie_ready0", req_ready0, !exp_g1[i]);
         chk("tie_ready1", req_ready1, exp_g1[i]);
         if (exp_g1[i]) push_model(2, 0, 3'b100);
         else           push_model(1, 0, 3'b001);
      end
      @(posedge clk); #1;
      req_valid0 = 1'b0; req_valid1 = 1'b0;
      @(negedge clk);
      expect_out("tie_out");

      send("clip_x", 0, 160, 0, 3'b011);
      send("clip_y", 0, 0, 121, 3'b011);

      // Clear sweep colliding with a request from requester 0.
      @(posedge clk); #1;
      req_valid0 = 1'b1; req_x0 = 12'd5; req_y0 = 12'd5; req_col0 = 3'b110;
      clear_req = 1'b1;
      @(negedge clk);
      chk("clr_collide_ready0", req_ready0, 0);
      @(posedge clk); #1 clear_req = 1'b0;
      plots = 0; dones = 0; bad_col = 0; bad_rdy = 0;
      first_x = -1; first_y = -1; last_x = -1; last_y = -1;
      cyc = 0;
      while (cyc < 80000) begin
         @(negedge clk);
         cyc++;
         if (vga_plot) begin
            if (plots == 0) begin first_x = vga_x; first_y = vga_y; end
            last_x = vga_x; last_y = vga_y;
            plots++;
            if (vga_colour !== 3'b000) bad_col++;
         end
         if (clear_done) begin dones++; break; end
         if (req_ready0 || !clear_busy) bad_rdy++;
      end
      chk("clr_done_seen", dones, 1);
      chk("clr_plot_count", plots, 76800);
      chk("clr_first", {first_x[15:0], first_y[15:0]}, {16'd0, 16'd0});
      chk("clr_last", {last_x[15:0], last_y[15:0]}, {16'd319, 16'd239});
      chk("clr_bad_colour", bad_col, 0);
      chk("clr_busy_ready", bad_rdy, 0);
      chk("clr_ready_after", req_ready0, 1);
      if (req_ready0) push_model(5, 5, 3'b110);
      @(posedge clk); #1 req_valid0 = 1'b0;
      @(negedge clk);
      chk("clr_done_once", {clear_done, clear_busy}, 0);
      expect_out("post_clear");

      // Reset in the middle of a sweep.
      @(posedge clk); #1 clear_req = 1'b1;
      @(posedge clk); #1 clear_req = 1'b0;
      plots = 0; dones = 0; cyc = 0;
      while (plots < 1000 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         if (vga_plot) plots++;
         if (clear_done) dones++;
      end
      chk("abort_plots", plots, 1000);
      chk("abort_no_done", dones, 0);
      #1 resetn = 1'b0;
      #1;
      chk("abort_outputs", {vga_plot, clipped, clear_done, clear_busy}, 0);
      chk("abort_xyc", {vga_x, vga_y, vga_colour}, 0);
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      bad_idle = 0;
      repeat (5) begin
         @(negedge clk);
         if (clear_busy || vga_plot || clear_done) bad_idle++;
      end
      chk("abort_no_sweep", bad_idle, 0);
      send("post_abort", 1, -10, 10, 3'b011);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/plot_port_arbiter.md
Name: plot_port_arbiter

Overview:
- Owns the single pixel-write port of the VGA adapter and shares it between two plot requesters, e.g. the data-point plotter and the fitted-curve sweeper.
- Converts signed math-space coordinates, with the origin at the screen centre and +y up, into adapter pixel coordinates, and drops points that fall off-screen.
- Runs a full-screen clear sweep on command; the sweep pre-empts both requesters.
- Sits between the plotting FSMs and the VGA adapter's x/y/colour/plot inputs.

Parameters:
- H_RES, 320, screen width in pixels.
- V_RES, 240, screen height in pixels.
- X_ORIGIN, 160, pixel column of math x=0.
- Y_ORIGIN, 120, pixel row of math y=0.
- BG_COLOUR, 3'b000, colour written during a clear sweep.

Ports:
- CLOCK_50  in  1  system clock; all logic is on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- clear_req  in  1  single-cycle pulse that starts a clear sweep.
- clear_busy  out  1  high while a sweep is in progress.
- clear_done  out  1  one-cycle pulse after the last sweep pixel is issued.
- req_valid0  in  1  requester 0 has a point.
- req_x0  in  12  signed math x, requester 0.
- req_y0  in  12  signed math y, requester 0.
- req_col0  in  3  colour, requester 0.
- req_ready0  out  1  requester 0 point accepted this cycle.
- req_valid1, req_x1, req_y1, req_col1, req_ready1  same as above, for requester 1.
- vga_x  out  9  adapter pixel column.
- vga_y  out  8  adapter pixel row.
- vga_colour  out  3  adapter colour.
- vga_plot  out  1  adapter write strobe.
- clipped  out  1  one-cycle pulse: the accepted point was off-screen and was dropped.

Behaviour:
- Reset: asynchronous, active-low on resetn. All outputs go to 0 and the FSM goes to SERVE. The arbitration pointer resets to favour requester 0.
- FSM states are SERVE and CLEAR.
- SERVE, no clear_req: at most one grant per cycle.
  - req_readyN is combinational: high only when the FSM is in SERVE, clear_req is low, req_validN is high, and requester N wins arbitration.
  - A transfer completes when valid and ready are both high in the same cycle.
  - A requester must hold valid, x, y and colour stable until ready is seen.
- SERVE + clear_req: go to CLEAR. Both ready outputs are low that cycle, so clear wins over any simultaneous request.
- Coordinate transform, computed 13-bit signed:
  - sx = x + X_ORIGIN
  - sy = Y_ORIGIN - y
  - The point is in range iff 0 <= sx < H_RES and 0 <= sy < V_RES.
- Output for an accepted point, in the cycle after acceptance (latency 1):
  - In range: vga_plot = 1, vga_x = sx[8:0], vga_y = sy[7:0], vga_colour = the requester's colour.
  - Out of range: vga_plot = 0 and clipped = 1. The requester is still acknowledged.
- Outputs hold their last x/y/colour values when idle. vga_plot and clipped are single-cycle pulses per accepted point.
- CLEAR:
  - Internal counters cx (0..H_RES-1) and cy (0..V_RES-1). cx increments every cycle; when it wraps it resets to 0 and cy increments.
  - Each cycle issues vga_plot = 1 with cx, cy and BG_COLOUR, registered with latency 1.
  - After pixel (H_RES-1, V_RES-1) is issued: clear_done pulses, the counters reset to 0, and the FSM returns to SERVE.
  - A full sweep is exactly H_RES*V_RES = 76800 writes.
  - clear_busy is high for every CLEAR cycle.
  - clear_req during CLEAR is ignored; the sweep does not restart.
  - Both ready outputs are low throughout CLEAR.
- Reset asserted mid-sweep: the sweep aborts immediately, outputs are 0, clear_done does not fire, and the FSM returns to SERVE.
- Arbitration without the optional feature: fixed priority, requester 0 over requester 1.

Optional Feature:
- Macro: PLOT_ARB_RR_EN.
- Defined: round-robin arbitration. A 1-bit pointer names the last-granted requester. When both requesters are valid, the other one is granted. A lone valid requester is always granted. The pointer updates only on a completed transfer and resets to 1, so requester 0 wins the first tie.
- Undefined: fixed priority as stated in Behaviour; the pointer logic is absent.

Test Plan:
- Reset, then requester 0 sends x=0, y=0, col=3'b101 -> req_ready0 = 1 the same cycle; next cycle vga_plot = 1, vga_x = 160, vga_y = 120, vga_colour = 101.
- Requester 1 sends x=-160, y=120 -> vga_x = 0, vga_y = 0. Then x=159, y=-119 -> vga_x = 319, vga_y = 239.
- Requester 0 sends x=160, y=0, then x=0, y=121 -> each acknowledged, vga_plot stays 0, clipped pulses once per point.
- Both requesters hold valid for 4 cycles:
  - Fixed priority: grants 0,0,0,0.
  - With PLOT_ARB_RR_EN: grants 0,1,0,1.
- clear_req pulsed in the same cycle as req_valid0 -> req_ready0 = 0; exactly 76800 vga_plot pulses with BG_COLOUR, the first at (0,0) and the last at (319,239); clear_done pulses once; req_ready0 rises the cycle after the return to SERVE.
- resetn pulled low after 1000 sweep pixels -> outputs are 0 immediately, no clear_done; after release, requests are served with no sweep.
